// File: rtl/alert_counter.sv
// Alarm sequencer: while enable is held, blink alert for ALERT_CYCLES cycles,
// then hold alert_off until enable drops. All outputs are registered.
module alert_counter #(
  parameter int ALERT_CYCLES = 10,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic alert,
  output logic alert_off
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALERT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ALERT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  // enable=0 overrides every state; alert tracks the parity of cnt_reg,
  // so it is 1 on odd counts and 0 on even ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      alert     <= 1'b0;
      alert_off <= 1'b0;
    end else if (!enable) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      alert     <= 1'b0;
      alert_off <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= ALERT;
          cnt_reg   <= CNT_ONE;
          alert     <= 1'b1;
          alert_off <= 1'b0;
        end
        ALERT: begin
          if (cnt_reg < CNT_LIMIT) begin
            cnt_reg <= cnt_reg + CNT_ONE;
            alert   <= ~alert;
          end else begin
            state_reg <= DONE;
            alert     <= 1'b0;
            alert_off <= 1'b1;
          end
        end
        DONE: begin
          alert     <= 1'b0;
          alert_off <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          alert     <= 1'b0;
          alert_off <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alert_counter.sv
// Directed bench for alert_counter: default instance plus an ALERT_CYCLES=2 instance.
module tb_alert_counter;

  logic clk;
  logic rst, enable, alert, alert_off;
  logic rst2, en2, alert2, alert_off2;
  int   checks = 0;
  int   errors = 0;

  alert_counter dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .alert     (alert),
    .alert_off (alert_off)
  );

  alert_counter #(.ALERT_CYCLES(2), .CNT_W(4)) dut2 (
    .clk       (clk),
    .rst       (rst2),
    .enable    (en2),
    .alert     (alert2),
    .alert_off (alert_off2)
  );

  initial begin
    clk = 1'b0;
    forever #25 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      $display("t=%0t ok   %s observed=%0h expected=%0h", $time, tag, obs, exp);
    else begin
      errors++;
      $display("t=%0t FAIL %s observed=%0h expected=%0h", $time, tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    rst2 = 1'b1; en2 = 1'b0;

    #5;
    chk("reset_alert", 8'(alert), 8'd0);
    chk("reset_off", 8'(alert_off), 8'd0);
    #5 rst = 1'b0;

    // Idle with enable low (edges 25, 75)
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_alert", 8'(alert), 8'd0);
      chk("idle_off", 8'(alert_off), 8'd0);
    end

    // Raise enable at t=100; edges 125..575 blink, 625 reaches DONE
    #24 enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("blink_alert", 8'(alert), (i % 2 == 0) ? 8'd1 : 8'd0);
      chk("blink_off", 8'(alert_off), 8'd0);
    end
    tick();
    chk("done_alert", 8'(alert), 8'd0);
    chk("done_off", 8'(alert_off), 8'd1);
    tick();
    chk("done_hold_alert", 8'(alert), 8'd0);
    chk("done_hold_off", 8'(alert_off), 8'd1);
    chk("done_cnt", 8'(dut.cnt_reg), 8'd10);

    // Drop enable in DONE, then hold low for 4 edges in total
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drop_alert", 8'(alert), 8'd0);
      chk("drop_off", 8'(alert_off), 8'd0);
    end

    // 4 cycles high, 1 low, then a full restart
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pre_drop_alert", 8'(alert), (i % 2 == 0) ? 8'd1 : 8'd0);
    end
    enable = 1'b0;
    tick();
    chk("gap_alert", 8'(alert), 8'd0);
    chk("gap_off", 8'(alert_off), 8'd0);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("restart_alert", 8'(alert), (i % 2 == 0) ? 8'd1 : 8'd0);
      chk("restart_off", 8'(alert_off), 8'd0);
    end
    tick();
    chk("restart_done_alert", 8'(alert), 8'd0);
    chk("restart_done_off", 8'(alert_off), 8'd1);

    // Async reset pulse between edges while cnt=3
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_alert", 8'(alert), 8'd1);
    chk("pre_rst_cnt", 8'(dut.cnt_reg), 8'd3);
    #10 rst = 1'b1;
    #1;
    chk("async_rst_alert", 8'(alert), 8'd0);
    chk("async_rst_cnt", 8'(dut.cnt_reg), 8'd0);
    #5 rst = 1'b0;
    tick();
    chk("post_rst_alert", 8'(alert), 8'd1);
    chk("post_rst_cnt", 8'(dut.cnt_reg), 8'd1);
    chk("post_rst_off", 8'(alert_off), 8'd0);

    // ALERT_CYCLES=2 instance
    rst2 = 1'b0;
    en2  = 1'b1;
    tick();
    chk("ac2_e1_alert", 8'(alert2), 8'd1);
    chk("ac2_e1_off", 8'(alert_off2), 8'd0);
    tick();
    chk("ac2_e2_alert", 8'(alert2), 8'd0);
    chk("ac2_e2_off", 8'(alert_off2), 8'd0);
    tick();
    chk("ac2_e3_alert", 8'(alert2), 8'd0);
    chk("ac2_e3_off", 8'(alert_off2), 8'd1);
    tick();
    chk("ac2_e4_off", 8'(alert_off2), 8'd1);
    chk("ac2_e4_cnt", 8'(dut2.cnt_reg), 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
